id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with load-use hazard detection for the pipelined MIPS core. It sits directly downstream of the main control unit and the register file. Each cycle it latches the decoded control bundle (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, jump) together with the operands into the EX stage. It inserts a bubble and raises `stall` on a load-use hazard, and inserts a bubble on a flush request.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate/PC width
- `CNT_W`, 16, bubble counter width

Ports:
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID stage holds a real instruction
- `id_pc_plus4` in DATA_W: PC+4 of ID instruction
- `id_rs`, `id_rt`, `id_rd` in 5 each: register specifiers
- `id_uses_rt` in 1: ID instruction reads rt as a source (R-type, sw, beq)
- `id_rs_data`, `id_rt_data` in DATA_W: register file read data
- `id_imm` in DATA_W: sign-extended immediate
- `id_funct` in 6: funct field
- `id_reg_dst`, `id_alu_src`, `id_mem_to_reg`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump` in 1 each: control unit outputs
- `id_alu_op` in 2: ALUOp from control unit
- `flush` in 1: squash the ID instruction (taken branch/jump resolved downstream)
- `stall` out 1: hold PC and IF/ID this cycle (combinational)
- `ex_valid` out 1: EX stage holds a real instruction
- `ex_pc_plus4`, `ex_rs_data`, `ex_rt_data`, `ex_imm` out DATA_W: registered copies
- `ex_rs`, `ex_rt`, `ex_write_reg` out 5 each: registered specifiers; `ex_write_reg` = reg_dst ? rd : rt, resolved at capture
- `ex_funct` out 6
- `ex_alu_src`, `ex_mem_to_reg`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jump` out 1 each
- `ex_alu_op` out 2
- `bubble_cnt` out CNT_W: saturating count of inserted bubbles

## Operation
- Hazard: `hz = id_valid & ex_valid & ex_mem_read & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_uses_rt & ex_write_reg == id_rt))`.
- `stall = hz & ~flush`. Flush has priority, because a squashed instruction need not wait.
- Per-cycle action, in priority order:
  - rst: all outputs cleared to 0, including `bubble_cnt`.
  - flush: capture a bubble. `ex_valid`, all ex control, specifiers and data are set to 0. `bubble_cnt` increments.
  - hz: capture a bubble (same encoding). `bubble_cnt` increments. Upstream holds, so the same ID instruction is re-presented next cycle.
  - otherwise: capture all id_* fields. `ex_valid <= id_valid`. If `id_valid=0`, control bits are captured as 0 regardless of the id_* control inputs.
- A bubble has all write/read enables at 0 and therefore cannot change architectural state.
- Only these sequential resources exist: the EX register set and the counter. Hazard logic is a pure function of the current id_* inputs and the current ex_* state.
- `bubble_cnt` saturates at 2^CNT_W−1 and does not wrap.
- `id_*` inputs with X (e.g. reg_dst on sw/beq) are captured as given. Downstream ignores them when the instruction does not use them. `ex_write_reg` is then don't-care, except that it is forced to 0 in bubbles.

## Timing
- Latency: one cycle. The ID fields present at posedge N appear on ex_* after edge N.
- `stall` is valid within the same cycle as the hazardous ID instruction and deasserts by itself on the next cycle, because EX then holds a bubble (`ex_mem_read=0`). A load-use hazard therefore costs exactly 1 stall cycle.
- Back-to-back lw → lw-use → use: each dependent pair stalls exactly once.
- Reset mid-stall: on the reset edge EX is cleared, and `stall` is 0 the following cycle.
- flush and hz in the same cycle: bubble inserted, `stall=0`, counter +1 (not +2).
- A register write to $0 never triggers a stall.

## Test plan
- Reset: assert rst 2 cycles with random id_* inputs → all ex_* = 0, `ex_valid=0`, `bubble_cnt=0`, `stall=0`.
- Pass-through: R-type add (rs=1, rt=2, rd=3, reg_dst=1, alu_op=10) → next cycle `ex_write_reg=3`, `ex_reg_write=1`, `ex_alu_op=10`, `ex_valid=1`, `stall=0`.
- Load-use: lw with rt=5, followed by add with rs=5 → `stall=1` for exactly one cycle, EX gets a bubble, the add reaches EX one cycle later, `bubble_cnt=1`.
- No false stall:
  - lw $0 then use of $0 → `stall=0`.
  - lw rt=5 then ori with rt=5 and `id_uses_rt=0` → `stall=0`.
- Flush priority: hazard condition plus `flush=1` → `stall=0`, bubble captured, `bubble_cnt` +1 only.
- Saturation: with CNT_W=4, force 20 consecutive flushes → `bubble_cnt` holds at 15.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and hazard status out.
// The master side is the upstream ID logic; the slave side is the pipeline register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]        id_funct;
  logic              id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic              id_mem_read, id_mem_write, id_branch, id_jump;
  logic [1:0]        id_alu_op;
  logic              flush;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_write_reg;
  logic [5:0]        ex_funct;
  logic              ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic              ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]        ex_alu_op;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc_plus4, id_rs, id_rt, id_rd, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_funct,
           id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_alu_op, flush,
    input  stall, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_write_reg, ex_funct,
           ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_alu_op, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc_plus4, id_rs, id_rt, id_rd, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_funct,
           id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_alu_op, flush,
    output stall, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_write_reg, ex_funct,
           ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_alu_op, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core with load-use hazard detection,
// flush squashing and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        write_reg;
    logic [5:0]        funct;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        alu_op;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             ctl_en;

  // A load in EX whose destination feeds the ID instruction; $0 is never a real dependency.
  assign hz = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.write_reg != 5'd0)
            & ((ex_q.write_reg == bus.id_rs)
               | (bus.id_uses_rt & (ex_q.write_reg == bus.id_rt)));

  assign bus.stall = hz & ~bus.flush;
  assign ctl_en    = bus.id_valid;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ex_d  = '0;
    cnt_d = cnt_q;
    if (bus.flush || hz) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid      = bus.id_valid;
      ex_d.pc_plus4   = bus.id_pc_plus4;
      ex_d.rs_data    = bus.id_rs_data;
      ex_d.rt_data    = bus.id_rt_data;
      ex_d.imm        = bus.id_imm;
      ex_d.rs         = bus.id_rs;
      ex_d.rt         = bus.id_rt;
      ex_d.write_reg  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      ex_d.funct      = bus.id_funct;
      ex_d.alu_src    = ctl_en & bus.id_alu_src;
      ex_d.mem_to_reg = ctl_en & bus.id_mem_to_reg;
      ex_d.reg_write  = ctl_en & bus.id_reg_write;
      ex_d.mem_read   = ctl_en & bus.id_mem_read;
      ex_d.mem_write  = ctl_en & bus.id_mem_write;
      ex_d.branch     = ctl_en & bus.id_branch;
      ex_d.jump       = ctl_en & bus.id_jump;
      ex_d.alu_op     = ctl_en ? bus.id_alu_op : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc_plus4   = ex_q.pc_plus4;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_write_reg  = ex_q.write_reg;
  assign bus.ex_funct      = ex_q.funct;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, load-use,
// false-stall cases, flush priority, reset mid-stall and counter saturation.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_pc_plus4 = '0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_uses_rt = 0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_funct = 0; bus.id_reg_dst = 0; bus.id_alu_src = 0; bus.id_mem_to_reg = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_branch = 0;
    bus.id_jump = 0; bus.id_alu_op = 0; bus.flush = 0;
  endtask

  task automatic drive_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive_idle();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_uses_rt = 1;
    bus.id_reg_dst = 1; bus.id_reg_write = 1; bus.id_alu_op = 2'b10; bus.id_funct = 6'h20;
    bus.id_rs_data = 32'd100; bus.id_rt_data = 32'd200; bus.id_pc_plus4 = 32'h104;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    drive_idle();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = 5'd31;
    bus.id_alu_src = 1; bus.id_mem_to_reg = 1; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_imm = 32'd4;
  endtask

  task automatic drive_ori(input logic [4:0] rs, input logic [4:0] rt);
    drive_idle();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_alu_src = 1;
    bus.id_reg_write = 1; bus.id_alu_op = 2'b11; bus.id_imm = 32'h0000_00ff;
  endtask

  task automatic test_reset();
    bus.id_valid = 1; bus.id_pc_plus4 = $urandom; bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
    bus.id_rd = 5'($urandom); bus.id_uses_rt = 1; bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
    bus.id_imm = $urandom; bus.id_funct = 6'($urandom); bus.id_reg_dst = 1; bus.id_alu_src = 1;
    bus.id_mem_to_reg = 1; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_write = 1;
    bus.id_branch = 1; bus.id_jump = 1; bus.id_alu_op = 2'b11; bus.flush = 0;
    rst = 1;
    tick(); tick();
    chk("reset_ex_valid", 32'(bus.ex_valid), 0);
    chk("reset_write_reg", 32'(bus.ex_write_reg), 0);
    chk("reset_reg_write", 32'(bus.ex_reg_write), 0);
    chk("reset_mem_read", 32'(bus.ex_mem_read), 0);
    chk("reset_rs_data", bus.ex_rs_data, 0);
    chk("reset_pc", bus.ex_pc_plus4, 0);
    chk("reset_alu_op", 32'(bus.ex_alu_op), 0);
    chk("reset_bubble_cnt", 32'(bus.bubble_cnt), 0);
    chk("reset_stall", 32'(bus.stall), 0);
    rst = 0;
    drive_idle();
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_pass_through();
    drive_rtype(5'd1, 5'd2, 5'd3);
    #1 chk("pt_stall", 32'(bus.stall), 0);
    tick();
    chk("pt_write_reg", 32'(bus.ex_write_reg), 3);
    chk("pt_reg_write", 32'(bus.ex_reg_write), 1);
    chk("pt_alu_op", 32'(bus.ex_alu_op), 2);
    chk("pt_valid", 32'(bus.ex_valid), 1);
    chk("pt_rs_data", bus.ex_rs_data, 100);
    chk("pt_rt_data", bus.ex_rt_data, 200);
    chk("pt_pc", bus.ex_pc_plus4, 32'h104);
    chk("pt_funct", 32'(bus.ex_funct), 32'h20);
    chk("pt_rs_rt", {22'd0, bus.ex_rs, bus.ex_rt}, {22'd0, 5'd1, 5'd2});
    chk("pt_stall_after", 32'(bus.stall), 0);
  endtask

  task automatic test_invalid_capture();
    drive_lw(5'd4, 5'd6);
    bus.id_valid = 0; bus.id_rs_data = 32'hdead_beef;
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 0);
    chk("inv_reg_write", 32'(bus.ex_reg_write), 0);
    chk("inv_mem_read", 32'(bus.ex_mem_read), 0);
    chk("inv_rs_data", bus.ex_rs_data, 32'hdead_beef);
    chk("inv_cnt", 32'(bus.bubble_cnt), 32'(exp_cnt));
  endtask

  task automatic test_load_use();
    drive_lw(5'd1, 5'd5);
    #1 chk("lu_lw_stall", 32'(bus.stall), 0);
    tick();
    chk("lu_lw_mem_read", 32'(bus.ex_mem_read), 1);
    chk("lu_lw_write_reg", 32'(bus.ex_write_reg), 5);
    drive_rtype(5'd5, 5'd2, 5'd6);
    #1 chk("lu_stall", 32'(bus.stall), 1);
    tick();
    exp_cnt++;
    chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
    chk("lu_bubble_reg_write", 32'(bus.ex_reg_write), 0);
    chk("lu_bubble_write_reg", 32'(bus.ex_write_reg), 0);
    chk("lu_cnt", 32'(bus.bubble_cnt), 32'(exp_cnt));
    chk("lu_stall_released", 32'(bus.stall), 0);
    tick();
    chk("lu_add_valid", 32'(bus.ex_valid), 1);
    chk("lu_add_write_reg", 32'(bus.ex_write_reg), 6);
    chk("lu_add_rs", 32'(bus.ex_rs), 5);
    chk("lu_cnt_held", 32'(bus.bubble_cnt), 32'(exp_cnt));
  endtask

  task automatic test_no_false_stall();
    drive_lw(5'd1, 5'd0);
    tick();
    drive_rtype(5'd0, 5'd0, 5'd7);
    #1 chk("nfs_zero_reg_stall", 32'(bus.stall), 0);
    drive_lw(5'd1, 5'd5);
    tick();
    drive_ori(5'd1, 5'd5);
    #1 chk("nfs_unused_rt_stall", 32'(bus.stall), 0);
    tick();
    chk("nfs_ori_valid", 32'(bus.ex_valid), 1);
    chk("nfs_cnt", 32'(bus.bubble_cnt), 32'(exp_cnt));
  endtask

  task automatic test_back_to_back();
    drive_lw(5'd1, 5'd7);
    tick();
    drive_lw(5'd7, 5'd8);
    #1 chk("b2b_lw2_stall", 32'(bus.stall), 1);
    tick();
    exp_cnt++;
    chk("b2b_lw2_stall_once", 32'(bus.stall), 0);
    tick();
    chk("b2b_lw2_in_ex", 32'(bus.ex_write_reg), 8);
    drive_rtype(5'd1, 5'd8, 5'd9);
    #1 chk("b2b_use_stall", 32'(bus.stall), 1);
    tick();
    exp_cnt++;
    chk("b2b_use_stall_once", 32'(bus.stall), 0);
    chk("b2b_cnt", 32'(bus.bubble_cnt), 32'(exp_cnt));
    tick();
    chk("b2b_use_in_ex", 32'(bus.ex_write_reg), 9);
    chk("b2b_use_valid", 32'(bus.ex_valid), 1);
  endtask

  task automatic test_flush_priority();
    drive_lw(5'd1, 5'd9);
    tick();
    drive_rtype(5'd9, 5'd2, 5'd10);
    bus.flush = 1;
    #1 chk("fp_stall", 32'(bus.stall), 0);
    tick();
    exp_cnt++;
    chk("fp_valid", 32'(bus.ex_valid), 0);
    chk("fp_reg_write", 32'(bus.ex_reg_write), 0);
    chk("fp_cnt", 32'(bus.bubble_cnt), 32'(exp_cnt));
    bus.flush = 0;
    #1 chk("fp_stall_after", 32'(bus.stall), 0);
  endtask

  task automatic test_reset_mid_stall();
    drive_lw(5'd1, 5'd10);
    tick();
    drive_rtype(5'd10, 5'd2, 5'd11);
    #1 chk("rms_stall", 32'(bus.stall), 1);
    rst = 1;
    tick();
    rst = 0;
    exp_cnt = 0;
    chk("rms_valid", 32'(bus.ex_valid), 0);
    chk("rms_cnt", 32'(bus.bubble_cnt), 0);
    chk("rms_stall_after", 32'(bus.stall), 0);
  endtask

  task automatic test_saturation();
    drive_rtype(5'd1, 5'd2, 5'd3);
    bus.flush = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (exp_cnt != 4'hf) exp_cnt++;
      chk($sformatf("sat_cnt_%0d", i), 32'(bus.bubble_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(bus.bubble_cnt), 15);
    chk("sat_valid", 32'(bus.ex_valid), 0);
    bus.flush = 0;
  endtask

  initial begin
    drive_idle();
    exp_cnt = 0;
    test_reset();
    test_pass_through();
    test_invalid_capture();
    test_load_use();
    test_no_false_stall();
    test_back_to_back();
    test_flush_priority();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
